// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: cascadable N-digit BCD up/down counter with
// synchronous clear/load, sticky wrap flag and saturating load with error flag.
module bcd_updown_counter #(
   parameter int DIGITS = 4
) (
   input  logic                  m_clock,
   input  logic                  m_reset_,
   input  logic                  m_ei,
   input  logic                  m_up,
   input  logic                  m_clr,
   input  logic                  m_ld,
   input  logic [4*DIGITS-1:0]   m_d,
   output logic [4*DIGITS-1:0]   q,
   output logic                  eu,
   output logic                  wrap,
   output logic                  ld_err
);
   logic [4*DIGITS-1:0] cnt_q, cnt_d, cnt_nxt, ld_val;
   logic                wrap_q, wrap_d, ld_err_q, ld_err_d, bad, c;

   // c walks up the digits as the ripple enable; after the loop it is the chain output
   always_comb begin
      c = m_ei;
      bad = 1'b0;
      cnt_nxt = cnt_q;
      ld_val = m_d;
      for (int k = 0; k < DIGITS; k++) begin
         cnt_nxt[4*k+:4] = cnt_q[4*k+:4] > 4'd9 ? (m_up ? 4'd0 : 4'd9) :
                           !c ? cnt_q[4*k+:4] :
                           m_up ? (cnt_q[4*k+:4] == 4'd9 ? 4'd0 : cnt_q[4*k+:4] + 4'd1) :
                                  (cnt_q[4*k+:4] == 4'd0 ? 4'd9 : cnt_q[4*k+:4] - 4'd1);
         c = c & (cnt_q[4*k+:4] == (m_up ? 4'd9 : 4'd0));
         ld_val[4*k+:4] = m_d[4*k+:4] > 4'd9 ? 4'd9 : m_d[4*k+:4];
         bad = bad | (m_d[4*k+:4] > 4'd9);
      end
      eu = c;
      cnt_d = m_clr ? '0 : m_ld ? ld_val : m_ei ? cnt_nxt : cnt_q;
      wrap_d = !m_clr & (wrap_q | (!m_ld & c));
      ld_err_d = m_clr ? 1'b0 : m_ld ? bad : ld_err_q;
   end

   always_ff @(posedge m_clock or negedge m_reset_) begin
      if (!m_reset_) begin
         cnt_q <= '0;
         wrap_q <= 1'b0;
         ld_err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         wrap_q <= wrap_d;
         ld_err_q <= ld_err_d;
      end
   end

   assign q = cnt_q;
   assign wrap = wrap_q;
   assign ld_err = ld_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed checks of a 4-digit counter against a
// decimal reference, plus a two-stage 2-digit cascade that must track it.
module tb_bcd_updown_counter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ei = 1'b0, up = 1'b1, clr = 1'b0, ld = 1'b0;
   logic [15:0] d = '0;
   logic [15:0] q4;
   logic [7:0]  q_lo, q_hi;
   logic        eu4, wrap4, err4, eu_lo, eu_hi, wrap_lo, wrap_hi, err_lo, err_hi;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(4)) u4 (
      .m_clock(clk), .m_reset_(rst_n), .m_ei(ei), .m_up(up), .m_clr(clr), .m_ld(ld),
      .m_d(d), .q(q4), .eu(eu4), .wrap(wrap4), .ld_err(err4));
   bcd_updown_counter #(.DIGITS(2)) u_lo (
      .m_clock(clk), .m_reset_(rst_n), .m_ei(ei), .m_up(up), .m_clr(clr), .m_ld(ld),
      .m_d(d[7:0]), .q(q_lo), .eu(eu_lo), .wrap(wrap_lo), .ld_err(err_lo));
   bcd_updown_counter #(.DIGITS(2)) u_hi (
      .m_clock(clk), .m_reset_(rst_n), .m_ei(eu_lo), .m_up(up), .m_clr(clr), .m_ld(ld),
      .m_d(d[15:8]), .q(q_hi), .eu(eu_hi), .wrap(wrap_hi), .ld_err(err_hi));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_chain(input string tag);
      check({tag, "_chain_q"}, {16'h0, q_hi, q_lo}, {16'h0, q4});
      check({tag, "_chain_eu"}, {31'h0, eu_hi}, {31'h0, eu4});
   endtask

   initial begin
      int v;
      #12;
      check("rst_q", {16'h0, q4}, 32'h0);
      check("rst_wrap", {31'h0, wrap4}, 32'h0);
      check("rst_err", {31'h0, err4}, 32'h0);
      rst_n = 1'b1;
      // count down from zero to set wrap, then load and count mid-way
      ei = 1'b1; up = 1'b0;
      tick();
      check("dn_wrap_q", {16'h0, q4}, 32'h9999);
      check("dn_wrap_flag", {31'h0, wrap4}, 32'h1);
      ld = 1'b1; d = 16'h0535; up = 1'b1;
      tick();
      ld = 1'b0;
      tick(); tick();
      check("mid_q", {16'h0, q4}, 32'h0537);
      check("mid_wrap_kept", {31'h0, wrap4}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_q", {16'h0, q4}, 32'h0);
      check("async_rst_wrap", {31'h0, wrap4}, 32'h0);
      check("async_rst_err", {31'h0, err4}, 32'h0);
      #3 rst_n = 1'b1;
      // full up sweep; cascade must match every cycle
      ei = 1'b1; up = 1'b1;
      for (int i = 0; i <= 10000; i++) begin
         check("up_q", {16'h0, q4}, {16'h0, to_bcd(i % 10000)});
         check("up_eu", {31'h0, eu4}, {31'h0, (i % 10000) == 9999});
         check("up_wrap", {31'h0, wrap4}, {31'h0, i >= 10000});
         check_chain("up");
         tick();
      end
      ei = 1'b0;
      v = 16'h0;
      tick(); tick();
      check("hold_q", {16'h0, q4}, 32'h0001);
      // down sweep through zero from a load of 0010
      clr = 1'b1;
      tick();
      clr = 1'b0; ld = 1'b1; d = 16'h0010; ei = 1'b1; up = 1'b0;
      tick();
      ld = 1'b0;
      v = 10;
      for (int i = 0; i <= 12; i++) begin
         check("dn_q", {16'h0, q4}, {16'h0, to_bcd(v)});
         check("dn_eu", {31'h0, eu4}, {31'h0, v == 0});
         check("dn_wrap", {31'h0, wrap4}, {31'h0, i >= 11});
         check_chain("dn");
         tick();
         v = v == 0 ? 9999 : v - 1;
      end
      // saturating load and error flag
      ld = 1'b1; d = 16'h1A3F; ei = 1'b0;
      tick();
      check("ld_sat_q", {16'h0, q4}, 32'h1939);
      check("ld_sat_err", {31'h0, err4}, 32'h1);
      check_chain("ld_sat");
      ld = 1'b0; ei = 1'b1; up = 1'b1;
      tick();
      check("cnt_keep_q", {16'h0, q4}, 32'h1940);
      check("cnt_keep_err", {31'h0, err4}, 32'h1);
      ld = 1'b1; d = 16'h0042;
      tick();
      check("ld_ok_q", {16'h0, q4}, 32'h0042);
      check("ld_ok_err", {31'h0, err4}, 32'h0);
      // clear beats load and count
      d = 16'h09F9;
      tick();
      check("pre_clr_q", {16'h0, q4}, 32'h0999);
      check("pre_clr_err", {31'h0, err4}, 32'h1);
      check("pre_clr_wrap", {31'h0, wrap4}, 32'h1);
      clr = 1'b1; d = 16'h1234;
      tick();
      check("clr_q", {16'h0, q4}, 32'h0);
      check("clr_wrap", {31'h0, wrap4}, 32'h0);
      check("clr_err", {31'h0, err4}, 32'h0);
      clr = 1'b0;
      tick();
      check("ld_no_inc", {16'h0, q4}, 32'h1234);
      // direction flip across the hundreds boundary
      d = 16'h0099;
      tick();
      ld = 1'b0;
      tick();
      check("flip_0100", {16'h0, q4}, 32'h0100);
      tick();
      check("flip_0101", {16'h0, q4}, 32'h0101);
      up = 1'b0;
      tick();
      check("flip_back_0100", {16'h0, q4}, 32'h0100);
      check_chain("flip_a");
      tick();
      check("flip_0099", {16'h0, q4}, 32'h0099);
      check_chain("flip_b");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
